// File: rtl/sata_pkg.sv
// sata_pkg: shared link-layer types, fis_err bit positions and CRC constants
package sata_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, CONT_SKIP} rx_state_e;
  localparam int ERR_CRC = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_ABORT = 2;
  localparam int ERR_SHORT = 3;
  localparam logic [31:0] CRC_SEED = 32'h52325032;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
endpackage

// File: rtl/sata_crc32_dword.sv
// sata_crc32_dword: combinational CRC-32 update over one dword, MSB first, no reflection
//   crc_i  current CRC      dat_i  dword to fold in      crc_o  updated CRC
module sata_crc32_dword
  import sata_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] dat_i,
  output logic [31:0] crc_o
);
  always_comb begin
    crc_o = crc_i;
    for (int i = 31; i >= 0; i--)
      crc_o = {crc_o[30:0], 1'b0} ^ ((crc_o[31] ^ dat_i[i]) ? CRC_POLY : 32'h0);
  end
endmodule

// File: rtl/sata_defs.svh
// sata_defs: SATA primitive dword encodings and the rx_datak qualifier values
`ifndef SATA_DEFS_SVH
`define SATA_DEFS_SVH
`define DWORD_IS_PRIM 1'b1
`define DWORD_IS_DATA 1'b0
`define SATA_PRIM_SOF   32'h3737B57C
`define SATA_PRIM_EOF   32'hD5D5B57C
`define SATA_PRIM_SYNC  32'hB5B5957C
`define SATA_PRIM_WTRM  32'h5858B57C
`define SATA_PRIM_CONT  32'h9999AA7C
`define SATA_PRIM_HOLD  32'hD5D5AA7C
`define SATA_PRIM_HOLDA 32'h9595AA7C
`define SATA_PRIM_ALIGN 32'h7B4A4ABC
`endif

// File: rtl/sata_fis_receiver.sv
// sata_fis_receiver: link-layer receive framer, SOF..EOF -> FIS beats with CRC strip/check
//   clk, reset (async, active-high)
//   rx_data/rx_datak      descrambled dword and primitive qualifier
//   fis_dat/fis_val       payload beat strobe
//   fis_eop/fis_err       end of frame and {short, abort, overflow, crc}
//   frame_active          a frame is in progress
`include "sata_defs.svh"
module sata_fis_receiver
  import sata_pkg::*;
#(
  parameter int MAX_DWORDS = 2049,
  parameter int CRC_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_data,
  input  logic        rx_datak,
  output logic [31:0] fis_dat,
  output logic        fis_val,
  output logic        fis_eop,
  output logic [3:0]  fis_err,
  output logic        frame_active
);
  localparam int CW = $clog2(MAX_DWORDS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_DWORDS + 1);
  rx_state_e state_q, state_d;
  logic [31:0] h0_q, h0_d, h1_q, h1_d, crc_q, crc_d, crc_nx, dat_q, dat_d;
  logic h0v_q, h0v_d, h1v_q, h1v_d, ovf_q, ovf_d, val_q, val_d, eop_q, eop_d, act_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic is_prim, is_sof, is_eof, is_cont, abort;
  assign is_prim = rx_datak == `DWORD_IS_PRIM;
  assign is_sof = is_prim && rx_data == `SATA_PRIM_SOF;
  assign is_eof = is_prim && rx_data == `SATA_PRIM_EOF;
  assign is_cont = is_prim && rx_data == `SATA_PRIM_CONT;
  assign abort = is_sof || (is_prim && (rx_data == `SATA_PRIM_SYNC || rx_data == `SATA_PRIM_WTRM));
  // CRC advances over h0 as it moves into h1, so the last dword held in h0 is never folded in
  sata_crc32_dword u_crc (.crc_i(crc_q), .dat_i(h0_q), .crc_o(crc_nx));
  always_comb begin
    state_d = state_q;
    h0_d = h0_q;
    h1_d = h1_q;
    h0v_d = h0v_q;
    h1v_d = h1v_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    crc_d = crc_q;
    dat_d = dat_q;
    val_d = 1'b0;
    eop_d = 1'b0;
    err_d = '0;
    if (state_q != IDLE && is_prim) begin
      state_d = is_cont ? CONT_SKIP : FRAME;
      if (is_eof || abort) begin
        state_d = IDLE;
        val_d = 1'b1;
        eop_d = 1'b1;
        dat_d = h1v_q ? h1_q : 32'h0;
        // h1 is valid exactly when at least two data dwords were accepted
        err_d[ERR_SHORT] = !h1v_q;
        err_d[ERR_ABORT] = abort;
        err_d[ERR_OVF] = ovf_q;
        err_d[ERR_CRC] = (CRC_CHECK != 0) && is_eof && h1v_q && crc_q != h0_q;
      end
    end else if (state_q == FRAME) begin
      if (cnt_q == CNT_FULL) ovf_d = 1'b1;
      else begin
        cnt_d = cnt_q + 1'b1;
        if (h1v_q) begin
          val_d = 1'b1;
          dat_d = h1_q;
        end
        if (h0v_q) begin
          h1_d = h0_q;
          h1v_d = 1'b1;
          crc_d = crc_nx;
        end
        h0_d = rx_data;
        h0v_d = 1'b1;
      end
    end
    // SOF opens a fresh context whether seen idle or as an in-frame abort
    if (is_sof) begin
      state_d = FRAME;
      h0v_d = 1'b0;
      h1v_d = 1'b0;
      cnt_d = '0;
      ovf_d = 1'b0;
      crc_d = CRC_SEED;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h0_q <= '0;
      h1_q <= '0;
      h0v_q <= 1'b0;
      h1v_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      crc_q <= CRC_SEED;
      dat_q <= '0;
      val_q <= 1'b0;
      eop_q <= 1'b0;
      err_q <= '0;
      act_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h0_q <= h0_d;
      h1_q <= h1_d;
      h0v_q <= h0v_d;
      h1v_q <= h1v_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      crc_q <= crc_d;
      dat_q <= dat_d;
      val_q <= val_d;
      eop_q <= eop_d;
      err_q <= err_d;
      act_q <= state_d != IDLE;
    end
  end
  assign fis_dat = dat_q;
  assign fis_val = val_q;
  assign fis_eop = eop_q;
  assign fis_err = err_q;
  assign frame_active = act_q;
endmodule

// File: tb/tb_sata_fis_receiver.sv
// tb_sata_fis_receiver: cycle table plus directed sequences for the receive framer
module tb_sata_fis_receiver;
  localparam logic [31:0] P_SOF = 32'h3737B57C;
  localparam logic [31:0] P_EOF = 32'hD5D5B57C;
  localparam logic [31:0] P_SYNC = 32'hB5B5957C;
  localparam logic [31:0] P_WTRM = 32'h5858B57C;
  localparam logic [31:0] P_CONT = 32'h9999AA7C;
  localparam logic [31:0] P_HOLD = 32'hD5D5AA7C;
  localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] SEED = 32'h52325032;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic K = 1'b1;
  localparam logic W = 1'b0;
  typedef struct {
    logic k;
    logic [31:0] d;
    logic val;
    logic eop;
    logic [31:0] dat;
    logic [3:0] err;
    logic act;
  } vec_t;
  typedef struct packed {
    logic eop;
    logic [3:0] err;
    logic [31:0] dat;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_datak = K;
  logic [31:0] rx_data = P_SYNC;
  logic [31:0] a_dat, b_dat, c_dat;
  logic a_val, b_val, c_val, a_eop, b_eop, c_eop, a_act, b_act, c_act;
  logic [3:0] a_err, b_err, c_err;
  beat_t qa[$], qb[$], qc[$];
  vec_t tv[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] d0, d1, c1, e1, e2, c3;
  logic [31:0] pv[6];
  sata_fis_receiver dut_a (.clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
    .fis_dat(a_dat), .fis_val(a_val), .fis_eop(a_eop), .fis_err(a_err), .frame_active(a_act));
  sata_fis_receiver #(.CRC_CHECK(0)) dut_b (.clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
    .fis_dat(b_dat), .fis_val(b_val), .fis_eop(b_eop), .fis_err(b_err), .frame_active(b_act));
  sata_fis_receiver #(.MAX_DWORDS(4)) dut_c (.clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
    .fis_dat(c_dat), .fis_val(c_val), .fis_eop(c_eop), .fis_err(c_err), .frame_active(c_act));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (a_val) qa.push_back(mk(a_eop, a_err, a_dat));
    if (b_val) qb.push_back(mk(b_eop, b_err, b_dat));
    if (c_val) qc.push_back(mk(c_eop, c_err, c_dat));
  end
  // direct-division form: xor the dword into the register, then shift 32 times
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction
  function automatic beat_t mk(input logic eop, input logic [3:0] err, input logic [31:0] dat);
    beat_t b;
    b.eop = eop;
    b.err = err;
    b.dat = dat;
    return b;
  endfunction
  function automatic vec_t nb(input logic k, input logic [31:0] d, input logic act);
    vec_t v;
    v.k = k; v.d = d; v.val = 1'b0; v.eop = 1'b0; v.dat = 32'h0; v.err = 4'h0; v.act = act;
    return v;
  endfunction
  function automatic vec_t bt(input logic k, input logic [31:0] d, input logic [31:0] dat,
                              input logic eop, input logic [3:0] err, input logic act);
    vec_t v;
    v.k = k; v.d = d; v.val = 1'b1; v.eop = eop; v.dat = dat; v.err = err; v.act = act;
    return v;
  endfunction
  task automatic check(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask
  task automatic send(input logic k, input logic [31:0] d);
    @(negedge clk);
    rx_datak = k;
    rx_data = d;
  endtask
  initial begin
    d0 = 32'h00000027;
    d1 = 32'h11223344;
    e1 = 32'hA5A50001;
    e2 = 32'hDEADBEEF;
    c1 = crc_step(crc_step(SEED, d0), d1);
    c3 = crc_step(crc_step(crc_step(SEED, d0), e1), e2);
    for (int i = 0; i < 6; i++) pv[i] = 32'h100 + 32'(i);
    tv.push_back(nb(K, P_SYNC, 0));
    tv.push_back(nb(W, 32'h12345678, 0));
    tv.push_back(nb(K, P_ALIGN, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(W, c1, d0, 0, 4'b0000, 1));
    tv.push_back(bt(K, P_EOF, d1, 1, 4'b0000, 0));
    tv.push_back(nb(K, P_SYNC, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(W, c1 ^ 32'h1, d0, 0, 4'b0000, 1));
    tv.push_back(bt(K, P_EOF, d1, 1, 4'b0001, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    for (int i = 0; i < 3; i++) tv.push_back(nb(K, P_HOLD, 1));
    tv.push_back(nb(W, e1, 1));
    tv.push_back(nb(K, P_CONT, 1));
    for (int i = 0; i < 5; i++) tv.push_back(nb(W, 32'hBAD00000 + 32'(i), 1));
    tv.push_back(nb(K, P_HOLD, 1));
    tv.push_back(bt(W, e2, d0, 0, 4'b0000, 1));
    tv.push_back(bt(W, c3, e1, 0, 4'b0000, 1));
    tv.push_back(bt(K, P_EOF, e2, 1, 4'b0000, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(K, P_SYNC, d0, 1, 4'b0100, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(bt(K, P_EOF, 32'h0, 1, 4'b1000, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(bt(K, P_EOF, 32'h0, 1, 4'b1000, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(W, e2, d0, 0, 4'b0000, 1));
    tv.push_back(bt(K, P_WTRM, d1, 1, 4'b0100, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(K, P_SOF, d0, 1, 4'b0100, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(W, c1, d0, 0, 4'b0000, 1));
    tv.push_back(bt(K, P_EOF, d1, 1, 4'b0000, 0));
    tv.push_back(nb(K, P_SOF, 1));
    tv.push_back(nb(W, d0, 1));
    tv.push_back(nb(W, d1, 1));
    tv.push_back(bt(W, c1, d0, 0, 4'b0000, 1));
    tv.push_back(nb(K, P_CONT, 1));
    tv.push_back(nb(W, 32'h55555555, 1));
    tv.push_back(bt(K, P_EOF, d1, 1, 4'b0000, 0));
    tv.push_back(nb(K, P_SYNC, 0));
    repeat (3) @(negedge clk);
    check({a_val, a_eop, a_err, a_dat, a_act} == 39'h0,
          $sformatf("reset_state got val=%b eop=%b err=%b dat=%h act=%b want all zero", a_val, a_eop, a_err, a_dat, a_act));
    reset = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].k, tv[i].d);
      @(posedge clk);
      #1;
      check(a_val === tv[i].val && a_eop === tv[i].eop && a_err === tv[i].err && a_act === tv[i].act &&
            (!tv[i].val || a_dat === tv[i].dat),
            $sformatf("row%0d got val=%b eop=%b dat=%h err=%b act=%b want val=%b eop=%b dat=%h err=%b act=%b",
                      i, a_val, a_eop, a_dat, a_err, a_act, tv[i].val, tv[i].eop, tv[i].dat, tv[i].err, tv[i].act));
    end
    qb.delete();
    send(K, P_SOF); send(W, d0); send(W, d1); send(W, c1 ^ 32'h1); send(K, P_EOF);
    send(K, P_SYNC); send(K, P_SYNC);
    check(qb.size() == 2, $sformatf("nocrc_beats got %0d want 2", qb.size()));
    if (qb.size() == 2)
      check(qb[1] == mk(1'b1, 4'h0, d1), $sformatf("nocrc_last got %h want %h", qb[1], mk(1'b1, 4'h0, d1)));
    check(b_act == 1'b0, $sformatf("nocrc_act got %b want 0", b_act));
    qc.delete();
    send(K, P_SOF);
    for (int i = 0; i < 6; i++) send(W, pv[i]);
    send(W, 32'hCAFEF00D); send(K, P_EOF);
    send(K, P_SYNC); send(K, P_SYNC);
    check(qc.size() == 4, $sformatf("ovf_beats got %0d want 4", qc.size()));
    for (int i = 0; i < 4; i++)
      if (i < qc.size())
        check(qc[i].dat == pv[i] && qc[i].eop == (i == 3) &&
              (qc[i].err & 4'b1110) == ((i == 3) ? 4'b0010 : 4'b0000) && (i == 3 || qc[i].err == 4'h0),
              $sformatf("ovf_beat%0d got dat=%h eop=%b err=%b want dat=%h eop=%b err=%s",
                        i, qc[i].dat, qc[i].eop, qc[i].err, pv[i], i == 3, (i == 3) ? "001x" : "0000"));
    check(c_act == 1'b0, $sformatf("ovf_act got %b want 0", c_act));
    qa.delete();
    send(K, P_SOF); send(W, d0); send(W, d1); send(W, e2);
    @(negedge clk);
    reset = 1'b1;
    rx_datak = K;
    rx_data = P_SYNC;
    #1;
    check({a_val, a_eop, a_err, a_dat, a_act} == 39'h0,
          $sformatf("midreset_state got val=%b eop=%b err=%b dat=%h act=%b want all zero", a_val, a_eop, a_err, a_dat, a_act));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(K, P_SOF); send(W, d0); send(W, d1); send(W, c1); send(K, P_EOF);
    send(K, P_SYNC); send(K, P_SYNC);
    check(qa.size() == 3, $sformatf("reset_beats got %0d want 3", qa.size()));
    if (qa.size() == 3) begin
      check(qa[0] == mk(1'b0, 4'h0, d0), $sformatf("reset_first got %h want %h", qa[0], mk(1'b0, 4'h0, d0)));
      check(qa[1] == mk(1'b0, 4'h0, d0), $sformatf("reset_clean0 got %h want %h", qa[1], mk(1'b0, 4'h0, d0)));
      check(qa[2] == mk(1'b1, 4'h0, d1), $sformatf("reset_clean1 got %h want %h", qa[2], mk(1'b1, 4'h0, d1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
